// File: rtl/dnn_mem_server.sv
// Parameter/activation memory for the inference engine: registered read port,
// plus a valid/ready loader that writes a word block at any base and pulses start.
module dnn_mem_server #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8192
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_data,
  input  logic                         load_req,
  input  logic [ADDR_WIDTH-1:0]        load_base,
  input  logic [ADDR_WIDTH-1:0]        load_len,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic                         busy,
  output logic                         start,
  output logic                         overflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  // The address space is wider than the implemented array; only the low part is backed.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  state_t                       state_r;
  state_t                       next_state_s;
  logic [ADDR_WIDTH-1:0]        wr_ptr_r;
  logic [ADDR_WIDTH-1:0]        remain_r;
  logic                         s_ready_r;
  logic                         busy_r;
  logic                         start_r;
  logic                         overflow_r;
  logic                         zero_len_r;
  logic                         hs_s;
  logic                         wr_en_s;
  logic                         last_hs_s;
  logic signed [DATA_WIDTH-1:0] mem_data_r;
  logic [DATA_WIDTH-1:0]        mem_r [DEPTH];

  assign hs_s = s_valid & s_ready_r;

  // Next-state decode and write enable for the loader FSM.
  always_comb begin
    next_state_s = state_r;
    wr_en_s      = 1'b0;
    last_hs_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_req) begin
          if (load_len == '0) begin
            next_state_s = FIN;
          end else begin
            next_state_s = LOAD;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (hs_s) begin
          wr_en_s = in_range(wr_ptr_r);
          if (remain_r == ADDR_WIDTH'(1)) begin
            last_hs_s    = 1'b1;
            next_state_s = FIN;
          end else begin
            next_state_s = LOAD;
          end
        end else begin
          next_state_s = LOAD;
        end
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, counters and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      wr_ptr_r   <= '0;
      remain_r   <= '0;
      s_ready_r  <= 1'b0;
      busy_r     <= 1'b0;
      start_r    <= 1'b0;
      overflow_r <= 1'b0;
      zero_len_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      s_ready_r <= (next_state_s == LOAD);
      busy_r    <= (next_state_s == LOAD);
      // An empty load spends its FIN cycle first, so its start lands one cycle later.
      start_r   <= last_hs_s | ((state_r == FIN) & zero_len_r);
      if ((state_r == IDLE) && load_req) begin
        wr_ptr_r   <= load_base;
        remain_r   <= load_len;
        overflow_r <= 1'b0;
        zero_len_r <= (load_len == '0);
      end else if (hs_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
        remain_r <= remain_r - ADDR_WIDTH'(1);
        if (!in_range(wr_ptr_r)) begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[IDX_W-1:0]] <= s_data;
    end
  end

  // Registered read port; a same-cycle write is not yet visible (read-before-write).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data_r <= '0;
    end else if (in_range(mem_addr)) begin
      mem_data_r <= $signed(mem_r[mem_addr[IDX_W-1:0]]);
    end else begin
      mem_data_r <= '0;
    end
  end

  assign mem_data = mem_data_r;
  assign s_ready  = s_ready_r;
  assign busy     = busy_r;
  assign start    = start_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_dnn_mem_server.sv
// Self-checking bench for dnn_mem_server: scenario tasks against an array/queue
// model of the memory, loader timing and sticky overflow.
module tb_dnn_mem_server;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       mem_addr;
  logic signed [8:0] mem_data;
  logic              load_req;
  logic [15:0]       load_base;
  logic [15:0]       load_len;
  logic              s_valid;
  logic [8:0]        s_data;
  logic              s_ready;
  logic              busy;
  logic              start;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  logic [8:0] ref_mem [0:8191];
  bit         ovf_m;
  logic [8:0] words_q[$];
  bit         vpat_q[$];

  bit   obs_timeout;
  int   obs_cycles;
  int   obs_proto_err;
  logic obs_start_next;
  logic obs_idle_next;
  logic obs_start_after2;
  logic obs_ovf_q[$];
  bit   exp_ovf_q[$];

  dnn_mem_server #(.DATA_WIDTH(9), .ADDR_WIDTH(16), .DEPTH(8192)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .load_req(load_req), .load_base(load_base), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .busy(busy), .start(start), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] exp_rd(input logic [15:0] a);
    if (a >= 16'd8192) return 9'h000;
    else return ref_mem[a[12:0]];
  endfunction

  task automatic do_read(input logic [15:0] a);
    mem_addr = a;
    tick();
  endtask

  // Drives one load (len > 0) and records what the DUT did; the model is updated per handshake.
  task automatic run_load(input logic [15:0] base, input logic [15:0] len, input int pct);
    int k;
    int cyc;
    bit v;
    logic [8:0] d;
    logic [15:0] a;
    load_req = 1'b1; load_base = base; load_len = len; s_valid = 1'b0;
    tick();
    load_req = 1'b0; load_base = 16'($urandom); load_len = 16'($urandom);
    ovf_m = 1'b0; k = 0; cyc = 0;
    obs_timeout = 1'b0; obs_proto_err = 0;
    obs_ovf_q.delete(); exp_ovf_q.delete();
    while (k < int'(len)) begin
      if (cyc >= 500) begin
        obs_timeout = 1'b1;
        break;
      end
      if (s_ready !== 1'b1 || busy !== 1'b1 || start !== 1'b0) obs_proto_err++;
      if (vpat_q.size() > 0) v = vpat_q.pop_front();
      else v = ($urandom_range(99) < pct);
      if (v && words_q.size() > 0) d = words_q.pop_front();
      else d = 9'($urandom);
      s_valid = v; s_data = d; a = base + 16'(k);
      tick();
      cyc++;
      if (v) begin
        if (a < 16'd8192) ref_mem[a[12:0]] = d;
        else ovf_m = 1'b1;
        k++;
        obs_ovf_q.push_back(overflow);
        exp_ovf_q.push_back(ovf_m);
      end
    end
    s_valid = 1'b0;
    obs_cycles = cyc;
    obs_start_next = start;
    obs_idle_next = (busy === 1'b0 && s_ready === 1'b0);
    tick();
    obs_start_after2 = start;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_addr = 16'h0000; load_req = 1'b0; load_base = 16'h0000;
    load_len = 16'h0000; s_valid = 1'b0; s_data = 9'h000;
    tick(); tick();
    checks++;
    if ({mem_data, s_ready, busy, start, overflow} !== 13'h0000) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0000", {mem_data, s_ready, busy, start, overflow});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({s_ready, busy, start, overflow} !== 4'h0) begin
      failures++;
      $display("FAIL reset_idle got=%b want=0000", {s_ready, busy, start, overflow});
    end
  endtask

  task automatic test_basic();
    int exp_sv[4] = '{1, -1, 128, -129};
    words_q = '{9'h001, 9'h1FF, 9'h080, 9'h17F};
    run_load(16'h0000, 16'd4, 100);
    checks++;
    if (obs_timeout || obs_proto_err != 0 || obs_cycles != 4) begin
      failures++;
      $display("FAIL basic_handshakes timeout=%0d errs=%0d cycles=%0d want 0 0 4",
               obs_timeout, obs_proto_err, obs_cycles);
    end
    checks++;
    if (obs_start_next !== 1'b1 || obs_idle_next !== 1'b1 || obs_start_after2 !== 1'b0) begin
      failures++;
      $display("FAIL basic_start start=%b idle=%b start2=%b want 1 1 0",
               obs_start_next, obs_idle_next, obs_start_after2);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(16'(i));
      checks++;
      if (int'(mem_data) != exp_sv[i]) begin
        failures++;
        $display("FAIL basic_read addr=%0d got=%0d want=%0d", i, int'(mem_data), exp_sv[i]);
      end
    end
  endtask

  task automatic test_preload();
    run_load(16'h0180, 16'd32, 100);
    checks++;
    if (obs_timeout || obs_proto_err != 0 || obs_start_next !== 1'b1) begin
      failures++;
      $display("FAIL preload_a timeout=%0d errs=%0d start=%b want 0 0 1",
               obs_timeout, obs_proto_err, obs_start_next);
    end
    run_load(16'h03FE, 16'd4, 100);
    checks++;
    if (obs_timeout || obs_proto_err != 0 || obs_start_next !== 1'b1) begin
      failures++;
      $display("FAIL preload_b timeout=%0d errs=%0d start=%b want 0 0 1",
               obs_timeout, obs_proto_err, obs_start_next);
    end
  endtask

  task automatic test_stall();
    vpat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_load(16'h0191, 16'd3, 100);
    checks++;
    if (obs_timeout || obs_proto_err != 0 || obs_cycles != 6) begin
      failures++;
      $display("FAIL stall_busy timeout=%0d errs=%0d cycles=%0d want 0 0 6",
               obs_timeout, obs_proto_err, obs_cycles);
    end
    checks++;
    if (obs_start_next !== 1'b1 || obs_idle_next !== 1'b1) begin
      failures++;
      $display("FAIL stall_start start=%b idle=%b want 1 1", obs_start_next, obs_idle_next);
    end
    for (int i = 16'h0190; i <= 16'h0194; i++) begin
      do_read(16'(i));
      checks++;
      if (mem_data !== exp_rd(16'(i))) begin
        failures++;
        $display("FAIL stall_read addr=%h got=%h want=%h", i, mem_data, exp_rd(16'(i)));
      end
    end
  endtask

  task automatic test_zero_len();
    int bad;
    bad = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 9'($urandom);
      tick();
      if (s_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_no_accept bad_cycles=%0d want 0", bad);
    end
    load_req = 1'b1; load_base = 16'h0180; load_len = 16'h0000;
    tick();
    load_req = 1'b0;
    checks++;
    if (start !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_cycle1 start=%b ready=%b want 0 0", start, s_ready);
    end
    tick();
    checks++;
    if (start !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_cycle2 start=%b ready=%b want 1 0", start, s_ready);
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (start !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_cycle3 start=%b ready=%b want 0 0", start, s_ready);
    end
    for (int i = 0; i < 2; i++) begin
      do_read(16'h0180 + 16'(i));
      checks++;
      if (mem_data !== exp_rd(16'h0180 + 16'(i))) begin
        failures++;
        $display("FAIL zero_mem addr=%h got=%h want=%h", 16'h0180 + 16'(i), mem_data,
                 exp_rd(16'h0180 + 16'(i)));
      end
    end
  endtask

  task automatic test_overflow();
    run_load(16'h1FFE, 16'd4, 100);
    checks++;
    if (obs_timeout || obs_ovf_q.size() != 4) begin
      failures++;
      $display("FAIL ovf_count timeout=%0d hs=%0d want 0 4", obs_timeout, obs_ovf_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_ovf_q[i] !== exp_ovf_q[i]) begin
          failures++;
          $display("FAIL ovf_after_hs%0d got=%b want=%b", i + 1, obs_ovf_q[i], exp_ovf_q[i]);
        end
      end
      checks++;
      if (obs_ovf_q[1] !== 1'b0 || obs_ovf_q[2] !== 1'b1) begin
        failures++;
        $display("FAIL ovf_third_hs hs2=%b hs3=%b want 0 1", obs_ovf_q[1], obs_ovf_q[2]);
      end
    end
    checks++;
    if (obs_start_next !== 1'b1) begin
      failures++;
      $display("FAIL ovf_start got=%b want 1", obs_start_next);
    end
    do_read(16'h2000);
    checks++;
    if (mem_data !== 9'h000) begin
      failures++;
      $display("FAIL ovf_read_2000 got=%h want=000", mem_data);
    end
    do_read(16'h1FFE);
    checks++;
    if (mem_data !== exp_rd(16'h1FFE)) begin
      failures++;
      $display("FAIL ovf_read_1ffe got=%h want=%h", mem_data, exp_rd(16'h1FFE));
    end
    do_read(16'h1FFF);
    checks++;
    if (mem_data !== exp_rd(16'h1FFF) || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky data=%h ovf=%b want %h 1", mem_data, overflow, exp_rd(16'h1FFF));
    end
    run_load(16'h0010, 16'd1, 100);
    checks++;
    if (obs_ovf_q.size() != 1 || obs_ovf_q[0] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_cleared size=%0d want 1 with flag 0", obs_ovf_q.size());
    end
  endtask

  task automatic test_rdw();
    words_q = '{9'h0AA};
    run_load(16'h0005, 16'd1, 100);
    load_req = 1'b1; load_base = 16'h0005; load_len = 16'd1;
    tick();
    load_req = 1'b0;
    mem_addr = 16'h0005; s_valid = 1'b1; s_data = 9'h055;
    tick();
    s_valid = 1'b0;
    ref_mem[5] = 9'h055;
    checks++;
    if (mem_data !== 9'h0AA || start !== 1'b1) begin
      failures++;
      $display("FAIL rdw_same_cycle data=%h start=%b want 0aa 1", mem_data, start);
    end
    tick();
    checks++;
    if (mem_data !== 9'h055) begin
      failures++;
      $display("FAIL rdw_next_cycle got=%h want=055", mem_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] d0;
    logic [8:0] d1;
    int bad;
    d0 = 9'($urandom); d1 = 9'($urandom);
    load_req = 1'b1; load_base = 16'h0300; load_len = 16'd5;
    tick();
    s_valid = 1'b1; s_data = d0;
    load_base = 16'h0400; load_len = 16'd1;
    tick();
    load_req = 1'b0; s_data = d1;
    tick();
    ref_mem[16'h0300] = d0; ref_mem[16'h0301] = d1;
    s_data = 9'($urandom);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mem_data, s_ready, busy, start, overflow} !== 13'h0000) begin
      failures++;
      $display("FAIL async_reset got=%h want=0000", {mem_data, s_ready, busy, start, overflow});
    end
    s_valid = 1'b0;
    #2 rst = 1'b1;
    ovf_m = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (start !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_no_start bad_cycles=%0d want 0", bad);
    end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] a;
      a = (i == 2) ? 16'h0400 : 16'h0300 + 16'(i);
      do_read(a);
      checks++;
      if (mem_data !== exp_rd(a)) begin
        failures++;
        $display("FAIL reset_retain addr=%h got=%h want=%h", a, mem_data, exp_rd(a));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [15:0] base;
      logic [15:0] len;
      logic [15:0] a;
      if (n == 7) base = 16'hFFFE;
      else if (n % 3 == 0) base = 16'(8190 - $urandom_range(0, 3));
      else base = 16'($urandom_range(0, 8191));
      len = 16'($urandom_range(1, 6));
      run_load(base, len, 60);
      checks++;
      if (obs_timeout || obs_proto_err != 0 || obs_start_next !== 1'b1 ||
          obs_idle_next !== 1'b1 || obs_start_after2 !== 1'b0) begin
        failures++;
        $display("FAIL rand_load n=%0d timeout=%0d errs=%0d start=%b idle=%b start2=%b", n,
                 obs_timeout, obs_proto_err, obs_start_next, obs_idle_next, obs_start_after2);
      end
      checks++;
      if (overflow !== ovf_m) begin
        failures++;
        $display("FAIL rand_ovf n=%0d got=%b want=%b", n, overflow, ovf_m);
      end
      for (int j = 0; j < 2; j++) begin
        a = base + 16'($urandom_range(0, int'(len) - 1));
        do_read(a);
        checks++;
        if (mem_data !== exp_rd(a)) begin
          failures++;
          $display("FAIL rand_read addr=%h got=%h want=%h", a, mem_data, exp_rd(a));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preload();
    test_stall();
    test_zero_len();
    test_overflow();
    test_rdw();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dnn_mem_server.md
Name: dnn_mem_server

Overview:
- Parameter/activation memory that answers the inference engine's read-only memory port: engine drives mem_addr, this block returns mem_data.
- Also the writer side: a valid/ready word stream loads an input image or weight block into any base address.
- When a load completes, it pulses start for the engine.
- Sits between the host-side loader (UART/DMA stream) and the dnn_relu_fix engine.

Parameters:
- DATA_WIDTH, 9, signed fixed-point word width; matches the engine's mem_data.
- ADDR_WIDTH, 16, address width of both ports.
- DEPTH, 8192, number of implemented words (1..2^ADDR_WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mem_addr  in  ADDR_WIDTH  engine read address.
- mem_data  out  DATA_WIDTH  signed read data, registered.
- load_req  in  1  one-cycle request to begin a load.
- load_base  in  ADDR_WIDTH  first write address; sampled with load_req.
- load_len  in  ADDR_WIDTH  word count; sampled with load_req.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_WIDTH  stream word.
- s_ready  out  1  stream word accepted when s_valid and s_ready are both 1.
- busy  out  1  high while loading.
- start  out  1  one-cycle pulse to the engine on load completion.
- overflow  out  1  sticky: a write address reached DEPTH or beyond.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_data=0, s_ready=0, busy=0, start=0, overflow=0; counters cleared. Memory contents are NOT cleared.
- Read port, always active in every state:
  - mem_data(t+1) = mem[mem_addr(t)]; latency 1 cycle.
  - mem_addr >= DEPTH returns 0.
  - Write and read to the same address in the same cycle: read returns the old word (read-before-write).
- FSM states: IDLE, LOAD, FIN.
  - IDLE: s_ready=0.
    - On load_req: latch wr_ptr=load_base, remain=load_len, clear overflow.
    - Go to FIN if load_len==0, else to LOAD.
  - LOAD: s_ready=1, busy=1.
    - Each handshake: write s_data to mem[wr_ptr] if wr_ptr < DEPTH, else drop the word and set overflow.
    - Then wr_ptr++ (wraps modulo 2^ADDR_WIDTH) and remain--.
    - On the handshake where remain==1: go to FIN; s_ready falls in the next cycle.
    - load_req is ignored while in LOAD.
  - FIN: busy=0; start=1 for exactly one cycle; return to IDLE.
    - load_req present in FIN is ignored; a new request is honoured only from IDLE.
- start is registered: high in the cycle after the final accepted word, or 2 cycles after load_req when len=0.
- s_valid with no load pending: not accepted (s_ready=0); data is ignored.
- Reset mid-load: FSM returns to IDLE immediately; words already written are retained; no start pulse.
- overflow: held until the next accepted load_req or reset.
- Data stored bit-exact; no sign extension or saturation.

Test Plan:
- Load base=0x0000, len=4, stream 9'h001,9'h1FF,9'h080,9'h17F (s_valid always 1):
  - 4 consecutive handshakes; start pulses once, in the cycle after the 4th.
  - Reads at addr 0..3 return 1, -1, 128, -129 (9'h080, 9'h17F as signed), each 1 cycle after the address.
- Stalling source, len=3 at base 0x0191, s_valid toggling 1,0,0,1,0,1:
  - Exactly 3 words written at 0x0191..0x0193.
  - busy stays high until the last handshake.
  - Reads at 0x0190 and 0x0194 unchanged.
- len=0: load_req -> start pulses 2 cycles later; s_ready never rises; memory unchanged.
- Overflow, DEPTH=8192, base=0x1FFE, len=4:
  - Addresses 0x1FFE and 0x1FFF written; 2 words dropped.
  - overflow=1 after the 3rd handshake; start still pulses.
  - Read 0x2000 returns 0.
- Read-during-write: mem_addr=0x0005 while writing 9'h055 there over old 9'h0AA:
  - Same-cycle read returns 9'h0AA; next cycle returns 9'h055.
- Async reset asserted after 2 of 5 words:
  - All outputs 0 without a clock edge; no start pulse.
  - Words 0..1 readable after release.
  - A second load_req during an active LOAD is ignored.
